// File: rtl/frequency_analyzer_scheduler.sv
// Ping-pong start/stop scheduler for two frequency analyzers, with a merged
// valid/ready result stream built from one pending slot per analyzer channel.
module frequency_analyzer_scheduler #(
  parameter int CLOCK        = 100000000,
  parameter int FREQUENCY    = 2000,
  parameter int SIGNAL_DELAY = 20,
  parameter int COUNT_WIDTH  = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   window_load,
  input  logic [31:0]            window_ticks_in,
  output logic                   start_analyzer_0,
  output logic                   stop_analyzer_0,
  output logic                   start_analyzer_1,
  output logic                   stop_analyzer_1,
  input  logic                   count_valid_0,
  input  logic                   count_valid_1,
  input  logic [COUNT_WIDTH-1:0] count_0,
  input  logic [COUNT_WIDTH-1:0] count_1,
  output logic [COUNT_WIDTH-1:0] result_data,
  output logic                   result_channel,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic                   overrun
);

  localparam logic [31:0] WINDOW_RESET = 32'(CLOCK / FREQUENCY);
  localparam logic [31:0] WINDOW_MIN   = 32'(2 * SIGNAL_DELAY);
  localparam logic [31:0] STROBE_LAST  = 32'(SIGNAL_DELAY - 1);

  // Strobe vector bit order: {stop_1, start_1, stop_0, start_0}
  localparam logic [3:0] STB_NONE   = 4'b0000;
  localparam logic [3:0] STB_PRIME  = 4'b0001;
  localparam logic [3:0] STB_DRAIN0 = 4'b0010;
  localparam logic [3:0] STB_SWAP01 = 4'b0110;
  localparam logic [3:0] STB_DRAIN1 = 4'b1000;
  localparam logic [3:0] STB_SWAP10 = 4'b1001;

  typedef enum logic [2:0] {
    IDLE, PRIME, WIN0, SWAP01, WIN1, SWAP10, DRAIN0, DRAIN1
  } state_t;

  state_t      state;
  logic [31:0] window;
  logic [31:0] phase;
  logic [3:0]  strobe;

  function automatic logic [31:0] clamp_window(input logic [31:0] ticks);
    return (ticks < WINDOW_MIN) ? WINDOW_MIN : ticks;
  endfunction

  assign start_analyzer_0 = strobe[0];
  assign stop_analyzer_0  = strobe[1];
  assign start_analyzer_1 = strobe[2];
  assign stop_analyzer_1  = strobe[3];

  // Phase counter runs continuously from PRIME entry, so strobe phases and
  // idle windows share one time base and boundaries stay exactly window apart.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      window <= WINDOW_RESET;
      phase  <= '0;
      strobe <= STB_NONE;
    end else begin
      unique case (state)
        IDLE: begin
          phase <= '0;
          if (window_load) window <= clamp_window(window_ticks_in);
          if (enable) begin
            state  <= PRIME;
            strobe <= STB_PRIME;
          end
        end
        PRIME, SWAP01, SWAP10: begin
          if (!enable) begin
            phase  <= '0;
            state  <= (state == SWAP01) ? DRAIN1 : DRAIN0;
            strobe <= (state == SWAP01) ? STB_DRAIN1 : STB_DRAIN0;
          end else begin
            phase <= phase + 32'd1;
            if (phase == STROBE_LAST) begin
              state  <= (state == SWAP01) ? WIN1 : WIN0;
              strobe <= STB_NONE;
            end
          end
        end
        WIN0, WIN1: begin
          if (!enable) begin
            phase  <= '0;
            state  <= (state == WIN1) ? DRAIN1 : DRAIN0;
            strobe <= (state == WIN1) ? STB_DRAIN1 : STB_DRAIN0;
          end else if (phase == window - 32'd1) begin
            phase  <= '0;
            state  <= (state == WIN0) ? SWAP01 : SWAP10;
            strobe <= (state == WIN0) ? STB_SWAP01 : STB_SWAP10;
          end else begin
            phase <= phase + 32'd1;
          end
        end
        DRAIN0, DRAIN1: begin
          if (phase == STROBE_LAST) begin
            phase  <= '0;
            state  <= IDLE;
            strobe <= STB_NONE;
          end else begin
            phase <= phase + 32'd1;
          end
        end
        default: begin
          state  <= IDLE;
          strobe <= STB_NONE;
        end
      endcase
    end
  end

  // Stage p0: per-channel pending slots
  logic [1:0]             vld_p0;
  logic [COUNT_WIDTH-1:0] slot0_p0;
  logic [COUNT_WIDTH-1:0] slot1_p0;
  logic                   prefer;
  logic                   take;
  logic                   load;
  logic                   pick_ch;
  logic [1:0]             consumed;
  logic                   lost;

  always_comb begin
    take     = !result_valid || result_ready;
    pick_ch  = (vld_p0 == 2'b11) ? prefer : vld_p0[1];
    load     = take && (vld_p0 != 2'b00);
    consumed = 2'b00;
    if (load) consumed[pick_ch] = 1'b1;
    lost     = (count_valid_0 && vld_p0[0] && !consumed[0]) ||
               (count_valid_1 && vld_p0[1] && !consumed[1]);
  end

  always_ff @(posedge clock) begin
    if (count_valid_0) slot0_p0 <= count_0;
    if (count_valid_1) slot1_p0 <= count_1;
  end

  // Stage p1: output register, held while the consumer stalls
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_p0         <= 2'b00;
      result_valid   <= 1'b0;
      result_data    <= '0;
      result_channel <= 1'b0;
      prefer         <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      vld_p0[0] <= count_valid_0 || (vld_p0[0] && !consumed[0]);
      vld_p0[1] <= count_valid_1 || (vld_p0[1] && !consumed[1]);
      if (take) result_valid <= load;
      if (load) begin
        result_data    <= pick_ch ? slot1_p0 : slot0_p0;
        result_channel <= pick_ch;
        prefer         <= !pick_ch;
      end
      if (lost) overrun <= 1'b1;
      else if (window_load) overrun <= 1'b0;
    end
  end

endmodule
